// File: rtl/csr_pkg.sv
// Shared Zicsr definitions: funct3 encodings, sequencer states and
// instruction field positions used by the CSR read-modify-write unit.
package csr_pkg;

    localparam logic [2:0] CSRRW  = 3'b001;
    localparam logic [2:0] CSRRS  = 3'b010;
    localparam logic [2:0] CSRRC  = 3'b011;
    localparam logic [2:0] CSRRWI = 3'b101;
    localparam logic [2:0] CSRRSI = 3'b110;
    localparam logic [2:0] CSRRCI = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } csr_rmw_state_t;

    localparam int ADDR_MSB   = 31;
    localparam int ADDR_LSB   = 20;
    localparam int RS1_MSB    = 19;
    localparam int RS1_LSB    = 15;
    localparam int FUNCT3_MSB = 14;
    localparam int FUNCT3_LSB = 12;
    localparam int RD_MSB     = 11;
    localparam int RD_LSB     = 7;

endpackage

// File: rtl/csr_alu.sv
// Combinational Zicsr read-modify-write datapath: new value, write enable
// and illegal-funct3 detection. Shared with the trap/interrupt logic.
module csr_alu
    import csr_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] old_val,
    input  logic [XLEN-1:0] rs1_val,
    input  logic [4:0]      rs1_idx,
    output logic [XLEN-1:0] new_val,
    output logic            we,
    output logic            illegal
);

    logic [XLEN-1:0] operand;

    always_comb begin
        // Immediate forms reuse the rs1 field as a zero-extended 5-bit zimm.
        operand = funct3[2] ? {{(XLEN-5){1'b0}}, rs1_idx} : rs1_val;
        new_val = '0;
        we      = 1'b0;
        illegal = 1'b0;
        case (funct3)
            CSRRW, CSRRWI: begin
                new_val = operand;
                we      = 1'b1;
            end
            CSRRS, CSRRSI: begin
                new_val = old_val | operand;
                we      = (rs1_idx != 5'd0);
            end
            CSRRC, CSRRCI: begin
                new_val = old_val & ~operand;
                we      = (rs1_idx != 5'd0);
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/csr_rmw_unit.sv
// Three-state sequencer in front of the CSR file: accept one instruction,
// issue a single-cycle read-modify-write, then hand back the old value.
module csr_rmw_unit
    import csr_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [31:0]     req_instr,
    input  logic [XLEN-1:0] req_rs1,
    output logic [31:0]     csr_instr,
    input  logic [XLEN-1:0] csr_rdata,
    output logic [3:0]      csr_ctrl,
    output logic [XLEN-1:0] csr_wdata,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_data,
    output logic [4:0]      resp_rd,
    output logic            resp_illegal
);

    csr_rmw_state_t  state_q, state_d;
    logic [31:0]     instr_q, instr_d;
    logic [XLEN-1:0] rs1_q, rs1_d;
    logic            req_ready_q, req_ready_d;
    logic            resp_valid_q, resp_valid_d;
    logic [XLEN-1:0] resp_data_q, resp_data_d;
    logic [4:0]      resp_rd_q, resp_rd_d;
    logic            resp_illegal_q, resp_illegal_d;

    logic [2:0]      funct3;
    logic [XLEN-1:0] alu_new;
    logic            alu_we;
    logic            alu_illegal;
    logic            exec_active;

    assign funct3 = instr_q[FUNCT3_MSB:FUNCT3_LSB];

    csr_alu #(.XLEN(XLEN)) u_alu (
        .funct3  (funct3),
        .old_val (csr_rdata),
        .rs1_val (rs1_q),
        .rs1_idx (instr_q[RS1_MSB:RS1_LSB]),
        .new_val (alu_new),
        .we      (alu_we),
        .illegal (alu_illegal)
    );

    always_comb begin
        state_d        = state_q;
        instr_d        = instr_q;
        rs1_d          = rs1_q;
        req_ready_d    = req_ready_q;
        resp_valid_d   = resp_valid_q;
        resp_data_d    = resp_data_q;
        resp_rd_d      = resp_rd_q;
        resp_illegal_d = resp_illegal_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    instr_d     = req_instr;
                    rs1_d       = req_rs1;
                    req_ready_d = 1'b0;
                    state_d     = EXEC;
                end
            end
            EXEC: begin
                resp_data_d    = alu_illegal ? '0 : csr_rdata;
                resp_rd_d      = instr_q[RD_MSB:RD_LSB];
                resp_illegal_d = alu_illegal;
                resp_valid_d   = 1'b1;
                state_d        = RESP;
            end
            RESP: begin
                if (resp_valid_q && resp_ready) begin
                    resp_valid_d = 1'b0;
                    req_ready_d  = 1'b1;
                    state_d      = IDLE;
                end
            end
            default: begin
                req_ready_d  = 1'b1;
                resp_valid_d = 1'b0;
                state_d      = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            instr_q        <= '0;
            rs1_q          <= '0;
            req_ready_q    <= 1'b1;
            resp_valid_q   <= 1'b0;
            resp_data_q    <= '0;
            resp_rd_q      <= '0;
            resp_illegal_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            instr_q        <= instr_d;
            rs1_q          <= rs1_d;
            req_ready_q    <= req_ready_d;
            resp_valid_q   <= resp_valid_d;
            resp_data_q    <= resp_data_d;
            resp_rd_q      <= resp_rd_d;
            resp_illegal_q <= resp_illegal_d;
        end
    end

    // Reset arriving mid-EXEC must cancel the write that would land on the same edge.
    assign exec_active  = (state_q == EXEC) && !reset;
    assign csr_ctrl     = exec_active ? {alu_we, funct3} : 4'b0000;
    assign csr_wdata    = exec_active ? alu_new : '0;

    assign csr_instr    = instr_q;
    assign req_ready    = req_ready_q;
    assign resp_valid   = resp_valid_q;
    assign resp_data    = resp_data_q;
    assign resp_rd      = resp_rd_q;
    assign resp_illegal = resp_illegal_q;

endmodule

// File: tb/tb_csr_rmw_unit.sv
// Randomized bench for csr_rmw_unit with a behavioural CSR file and a
// transaction-level reference model of the Zicsr read-modify-write rules.
module tb_csr_rmw_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_instr;
    logic [31:0] req_rs1;
    logic [31:0] csr_instr;
    logic [31:0] csr_rdata;
    logic [3:0]  csr_ctrl;
    logic [31:0] csr_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_data;
    logic [4:0]  resp_rd;
    logic        resp_illegal;

    always #5 clk = ~clk;

    csr_rmw_unit #(.XLEN(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_instr    (req_instr),
        .req_rs1      (req_rs1),
        .csr_instr    (csr_instr),
        .csr_rdata    (csr_rdata),
        .csr_ctrl     (csr_ctrl),
        .csr_wdata    (csr_wdata),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_data    (resp_data),
        .resp_rd      (resp_rd),
        .resp_illegal (resp_illegal)
    );

    // Behavioural CSR file: combinational read, write on the clock edge.
    logic [31:0] file_mem [4096];
    logic        tb_wr_en;
    logic [11:0] tb_wr_addr;
    logic [31:0] tb_wr_data;

    assign csr_rdata = file_mem[csr_instr[31:20]];

    always @(posedge clk) begin
        if (tb_wr_en)
            file_mem[tb_wr_addr] <= tb_wr_data;
        else if (csr_ctrl[3])
            file_mem[csr_instr[31:20]] <= csr_wdata;
    end

    logic [31:0] ref_mem [4096];
    logic [11:0] addrs [8];
    int          errors = 0;
    int          checks = 0;
    logic [31:0] seen_ctrl;
    logic [31:0] seen_wdata;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mk_instr(input logic [11:0] addr, input logic [4:0] idx,
                                             input logic [2:0] f3, input logic [4:0] rd);
        return {addr, idx, f3, rd, 7'h73};
    endfunction

    task automatic set_csr(input logic [11:0] a, input logic [31:0] d);
        @(negedge clk);
        tb_wr_en = 1'b1; tb_wr_addr = a; tb_wr_data = d;
        @(negedge clk);
        tb_wr_en = 1'b0;
        ref_mem[a] = d;
    endtask

    task automatic run_txn(input logic [11:0] addr, input logic [4:0] idx, input logic [2:0] f3,
                           input logic [4:0] rd, input logic [31:0] rs1v, input int stall);
        logic [31:0] old, op, nv, exp_data, instr;
        logic        we, ill;
        old   = ref_mem[addr];
        op    = f3[2] ? {27'd0, idx} : rs1v;
        ill   = (f3 == 3'b000) || (f3 == 3'b100);
        case (f3[1:0])
            2'b01:   nv = op;
            2'b10:   nv = old | op;
            default: nv = old & ~op;
        endcase
        we       = !ill && ((f3[1:0] == 2'b01) || (idx != 5'd0));
        exp_data = ill ? 32'd0 : old;
        instr    = mk_instr(addr, idx, f3, rd);

        @(negedge clk);
        check("req_ready_idle", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1; req_instr = instr; req_rs1 = rs1v;
        @(negedge clk);
        req_valid = 1'b0; req_instr = $urandom; req_rs1 = $urandom;
        seen_ctrl  = {28'd0, csr_ctrl};
        seen_wdata = csr_wdata;
        check("exec_req_ready", {31'd0, req_ready}, 32'd0);
        check("exec_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("exec_csr_instr", csr_instr, instr);
        check("exec_ctrl", seen_ctrl, {28'd0, we, f3});
        if (!ill) check("exec_wdata", seen_wdata, nv);
        if (we) ref_mem[addr] = nv;

        for (int i = 0; i <= stall; i++) begin
            @(negedge clk);
            check("resp_valid", {31'd0, resp_valid}, 32'd1);
            check("resp_data", resp_data, exp_data);
            check("resp_rd", {27'd0, resp_rd}, {27'd0, rd});
            check("resp_illegal", {31'd0, resp_illegal}, {31'd0, ill});
            check("resp_ctrl_idle", {28'd0, csr_ctrl}, 32'd0);
            check("resp_req_ready", {31'd0, req_ready}, 32'd0);
            resp_ready = (i == stall);
        end
        @(negedge clk);
        check("ret_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("ret_req_ready", {31'd0, req_ready}, 32'd1);
        check("ret_csr_instr", csr_instr, instr);
        resp_ready = 1'b0;
        $display("txn addr=%h f3=%b idx=%0d rd=%0d rs1=%h old=%h we=%0d new=%h ill=%0d",
                 addr, f3, idx, rd, rs1v, old, we, nv, ill);
    endtask

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_instr = '0; req_rs1 = '0;
        resp_ready = 1'b0; tb_wr_en = 1'b0; tb_wr_addr = '0; tb_wr_data = '0;
        addrs[0] = 12'h305; addrs[1] = 12'h300; addrs[2] = 12'h340; addrs[3] = 12'h341;
        addrs[4] = 12'h7C0; addrs[5] = 12'h001; addrs[6] = 12'h002; addrs[7] = 12'h003;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_req_ready", {31'd0, req_ready}, 32'd1);
        check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("rst_resp_illegal", {31'd0, resp_illegal}, 32'd0);
        check("rst_resp_data", resp_data, 32'd0);
        check("rst_resp_rd", {27'd0, resp_rd}, 32'd0);
        check("rst_csr_instr", csr_instr, 32'd0);
        check("rst_csr_ctrl", {28'd0, csr_ctrl}, 32'd0);
        check("rst_csr_wdata", csr_wdata, 32'd0);
        for (int i = 0; i < 8; i++) set_csr(addrs[i], $urandom);

        set_csr(12'h305, 32'h0000_0010);
        run_txn(12'h305, 5'd5, 3'b001, 5'd10, 32'hDEAD_BEEF, 0);
        check("csrrw_ctrl", seen_ctrl, 32'h9);
        check("csrrw_wdata", seen_wdata, 32'hDEAD_BEEF);

        set_csr(12'h300, 32'h0F0F_0000);
        run_txn(12'h300, 5'd7, 3'b010, 5'd3, 32'h0000_00FF, 1);
        check("csrrs_wdata", seen_wdata, 32'h0F0F_00FF);
        set_csr(12'h300, 32'h0F0F_0000);
        run_txn(12'h300, 5'd0, 3'b010, 5'd4, 32'h0, 0);
        check("csrrs_x0_we", {31'd0, seen_ctrl[3]}, 32'd0);

        set_csr(12'h340, 32'hFFFF_FFFF);
        run_txn(12'h340, 5'b00110, 3'b111, 5'd8, 32'h1234_5678, 0);
        check("csrrci_wdata", seen_wdata, 32'hFFFF_FFF9);
        check("csrrci_ctrl", seen_ctrl, 32'hF);
        run_txn(12'h340, 5'd0, 3'b111, 5'd9, 32'h0, 0);
        check("csrrci_z0_we", {31'd0, seen_ctrl[3]}, 32'd0);

        run_txn(12'h341, 5'd3, 3'b100, 5'd11, 32'hFFFF_FFFF, 0);
        check("illegal_we", {31'd0, seen_ctrl[3]}, 32'd0);

        run_txn(12'h001, 5'd12, 3'b001, 5'd13, 32'hA5A5_5A5A, 5);

        // Reset during EXEC: no write, outputs back to reset values.
        @(negedge clk);
        req_valid = 1'b1; req_instr = mk_instr(12'h002, 5'd1, 3'b001, 5'd2); req_rs1 = 32'hCAFE_F00D;
        @(negedge clk);
        req_valid = 1'b0;
        reset = 1'b1;
        #1;
        check("rstexec_we", {31'd0, csr_ctrl[3]}, 32'd0);
        @(negedge clk);
        check("rstexec_req_ready", {31'd0, req_ready}, 32'd1);
        check("rstexec_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("rstexec_resp_data", resp_data, 32'd0);
        check("rstexec_resp_rd", {27'd0, resp_rd}, 32'd0);
        check("rstexec_illegal", {31'd0, resp_illegal}, 32'd0);
        check("rstexec_csr_instr", csr_instr, 32'd0);
        check("rstexec_ctrl", {28'd0, csr_ctrl}, 32'd0);
        check("rstexec_wdata", csr_wdata, 32'd0);
        check("rstexec_mem", file_mem[12'h002], ref_mem[12'h002]);
        reset = 1'b0;

        run_txn(12'h7C0, 5'd6, 3'b001, 5'd14, 32'h1234_5678, 0);
        run_txn(12'h7C0, 5'd0, 3'b010, 5'd15, 32'h0, 0);
        check("raw_resp_data", resp_data, 32'h1234_5678);

        for (int n = 0; n < 60; n++) begin
            logic [4:0]  idx;
            logic [31:0] rv;
            idx = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
            rv  = (idx == 5'd0) ? 32'd0 : $urandom;
            run_txn(addrs[$urandom_range(0, 7)], idx, 3'($urandom_range(0, 7)),
                    5'($urandom), rv, $urandom_range(0, 3));
        end

        for (int i = 0; i < 8; i++) check("final_mem", file_mem[addrs[i]], ref_mem[addrs[i]]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
